sync_fifo_flagged: RTL

//  Single-clock, parametrised FIFO for buffering 16-bit data between producer/consumer stages in one clock domain.

---
 rtl/sync_fifo_flagged_pkg.sv | 24 ++
 rtl/sync_fifo_flagged_if.sv | 27 ++
 rtl/sync_fifo_flagged_fifo_mem_dp.sv | 17 +
 rtl/sync_fifo_flagged.sv | 72 +++++++
 4 files changed

// File: rtl/sync_fifo_flagged_pkg.sv
// sync_fifo_flagged_pkg: shared constants, flag bundle type and parameter range checks for the flagged FIFO
package sync_fifo_flagged_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;
  localparam flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit afull_ok(input int t, input int depth);
    return t >= 1 && t <= depth;
  endfunction
  function automatic bit aempty_ok(input int t, input int depth);
    return t >= 0 && t <= depth - 1;
  endfunction
endpackage

// File: rtl/sync_fifo_flagged_if.sv
// sync_fifo_flagged_if: write/read handshake, status flags and error-clear bundle between a FIFO and its user
interface sync_fifo_flagged_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;
  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flagged_fifo_mem_dp.sv
// fifo_mem_dp: DEPTH x DATA_WIDTH register array, synchronous write port, asynchronous read port
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with registered occupancy flags, sticky error flags and optional FWFT read
module sync_fifo_flagged
  import sync_fifo_flagged_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b0
) (
  input logic                clk,
  input logic                reset_n,
  sync_fifo_flagged_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  if (!afull_ok(AFULL_THRESH, DEPTH) || !aempty_ok(AEMPTY_THRESH, DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_flagged: threshold parameters out of range");
  end
  logic [PW-1:0]         wr_ptr, rd_ptr, count_q, count_d;
  flags_t                flags_q, flags_d;
  logic                  wr_acc, rd_acc, rd_valid_q, ovf_q, udf_q;
  logic [DATA_WIDTH-1:0] head, rd_q;
  assign wr_acc = bus.wr_en && !flags_q.full;
  assign rd_acc = bus.rd_en && !flags_q.empty;
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (head)
  );
  // Flags are derived from the next count so they describe occupancy after this edge
  always_comb begin
    count_d              = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    flags_d.full         = count_d == PW'(DEPTH);
    flags_d.empty        = count_d == '0;
    flags_d.almost_full  = count_d >= PW'(AFULL_THRESH);
    flags_d.almost_empty = count_d <= PW'(AEMPTY_THRESH);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      flags_q    <= FLAGS_RESET;
      rd_valid_q <= 1'b0;
      rd_q       <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(wr_acc);
      rd_ptr     <= rd_ptr + PW'(rd_acc);
      count_q    <= count_d;
      flags_q    <= flags_d;
      rd_valid_q <= rd_acc;
      rd_q       <= rd_acc ? head : rd_q;
      ovf_q      <= (bus.wr_en && flags_q.full) || (ovf_q && !bus.clr_err);
      udf_q      <= (bus.rd_en && flags_q.empty) || (udf_q && !bus.clr_err);
    end
  end
  assign bus.rd_data      = FWFT ? head : rd_q;
  assign bus.rd_valid     = FWFT ? !flags_q.empty : rd_valid_q;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
